// File: rtl/hpdmc_pkg.sv
// rtl/hpdmc_pkg.sv - shared encodings and widths for the HPDMC refresh scheduler
package hpdmc_pkg;
  localparam int TIM_RP_W   = 3;
  localparam int TIM_RFC_W  = 4;
  localparam int TIM_REFI_W = 11;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP       = 3'b111;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;

  localparam logic [12:0] ADR_PRE_ALL = 13'h0400;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_PRE      = 3'd2;
  localparam logic [2:0] S_WAIT_RP  = 3'd3;
  localparam logic [2:0] S_REF      = 3'd4;
  localparam logic [2:0] S_WAIT_RFC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_DRAIN    = S_DRAIN,
    ST_PRE      = S_PRE,
    ST_WAIT_RP  = S_WAIT_RP,
    ST_REF      = S_REF,
    ST_WAIT_RFC = S_WAIT_RFC
  } state_t;
endpackage

// File: rtl/hpdmc_refi_timer.sv
// rtl/hpdmc_refi_timer.sv - tREFI down-counter and owed-refresh tracking
// Macro HPDMC_REFRESH_POSTPONE_EN widens the owed flag into a saturating credit counter.
module hpdmc_refi_timer
  import hpdmc_pkg::*;
#(
  parameter int REF_CREDITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [TIM_REFI_W-1:0] tim_refi,
  input  logic                  ref_done,
  input  logic                  clear,
  output logic                  pending,
  output logic                  pending_nxt,
  output logic                  urgent,
  output logic                  urgent_nxt
);
`ifdef HPDMC_REFRESH_POSTPONE_EN
  localparam int CREDIT_MAX = REF_CREDITS;
`else
  localparam int CREDIT_MAX = 1;
`endif
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDIT_MAX);

  logic [TIM_REFI_W-1:0] cnt;
  logic [CW-1:0]         credits;
  logic [CW-1:0]         credits_nxt;
  logic                  expire;

  assign expire = enable && (cnt == '0);

  // A new expiry and a REF in the same cycle cancel, so the owed count holds.
  always_comb begin
    credits_nxt = credits;
    if (clear)
      credits_nxt = '0;
    else if (expire && !ref_done) begin
      if (credits != FULL)
        credits_nxt = credits + CW'(1);
    end else if (ref_done && !expire && credits != '0)
      credits_nxt = credits - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      credits <= '0;
    end else begin
      credits <= credits_nxt;
      if (!enable || expire)
        cnt <= tim_refi;
      else
        cnt <= cnt - TIM_REFI_W'(1);
    end
  end

  assign pending     = credits != '0;
  assign pending_nxt = credits_nxt != '0;
  assign urgent      = credits == FULL;
  assign urgent_nxt  = credits_nxt == FULL;
endmodule

// File: rtl/hpdmc_refresh_sched.sv
// rtl/hpdmc_refresh_sched.sv - auto-refresh sequencer and command-bus arbiter
// Macro HPDMC_REFRESH_POSTPONE_EN enables postponed refreshes with back-to-back REFs.
module hpdmc_refresh_sched
  import hpdmc_pkg::*;
#(
  parameter int REF_CREDITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic [TIM_RP_W-1:0]   tim_rp,
  input  logic [TIM_RFC_W-1:0]  tim_rfc,
  input  logic [TIM_REFI_W-1:0] tim_refi,
  input  logic                  dp_idle,
  output logic                  dp_gnt,
  output logic                  ref_busy,
  output logic                  ref_pending,
  output logic                  cmd_cs_n,
  output logic                  cmd_ras_n,
  output logic                  cmd_cas_n,
  output logic                  cmd_we_n,
  output logic [12:0]           cmd_adr,
  output logic [1:0]            cmd_ba
);
`ifdef HPDMC_REFRESH_POSTPONE_EN
  localparam state_t RETRY = ST_REF;
`else
  localparam state_t RETRY = ST_DRAIN;
`endif

  state_t                state;
  state_t                after_rfc;
  logic [TIM_RFC_W-1:0]  wcnt;
  logic                  pending, pending_nxt, urgent, urgent_nxt;
  logic                  ref_done, clear, start, gnt_nxt, wait_last;

  hpdmc_refi_timer #(.REF_CREDITS(REF_CREDITS)) u_timer (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .enable     (enable),
    .tim_refi   (tim_refi),
    .ref_done   (ref_done),
    .clear      (clear),
    .pending    (pending),
    .pending_nxt(pending_nxt),
    .urgent     (urgent),
    .urgent_nxt (urgent_nxt)
  );

  assign ref_done  = state == ST_REF;
  assign clear     = (state == ST_DRAIN) && !enable;
  assign start     = enable && (urgent || (pending && dp_idle));
  assign gnt_nxt   = enable && !(urgent_nxt || (pending_nxt && dp_idle));
  assign after_rfc = (enable && pending_nxt) ? RETRY : ST_IDLE;
  assign wait_last = wcnt <= TIM_RFC_W'(1);

  assign ref_pending = pending;
  assign cmd_ba      = '0;

  // Commands are registered from the current state, so they trail state entry by one cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      dp_gnt   <= 1'b0;
      ref_busy <= 1'b0;
      cmd_cs_n <= 1'b1;
      {cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_NOP;
      cmd_adr  <= '0;
    end else begin
      cmd_cs_n <= !(state == ST_PRE || state == ST_REF);
      case (state)
        ST_PRE:  {cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_PRECHARGE;
        ST_REF:  {cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_REFRESH;
        default: {cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_NOP;
      endcase
      cmd_adr <= (state == ST_PRE) ? ADR_PRE_ALL : '0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_DRAIN;
            dp_gnt   <= 1'b0;
            ref_busy <= 1'b1;
          end else begin
            dp_gnt <= gnt_nxt;
          end
        end
        ST_DRAIN: begin
          if (!enable) begin
            state    <= ST_IDLE;
            ref_busy <= 1'b0;
          end else if (dp_idle) begin
            state <= ST_PRE;
          end
        end
        ST_PRE: begin
          wcnt  <= TIM_RFC_W'(tim_rp);
          state <= (tim_rp == '0) ? ST_REF : ST_WAIT_RP;
        end
        ST_WAIT_RP: begin
          wcnt <= wcnt - TIM_RFC_W'(1);
          if (wait_last)
            state <= ST_REF;
        end
        ST_REF: begin
          wcnt <= tim_rfc;
          if (tim_rfc == '0) begin
            state    <= after_rfc;
            ref_busy <= after_rfc != ST_IDLE;
          end else begin
            state <= ST_WAIT_RFC;
          end
        end
        ST_WAIT_RFC: begin
          wcnt <= wcnt - TIM_RFC_W'(1);
          if (wait_last) begin
            state    <= after_rfc;
            ref_busy <= after_rfc != ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ref_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/hpdmc_refresh_sched.md
Name: hpdmc_refresh_sched

Overview:
Auto-refresh scheduler and command-bus arbiter for the DDR SDRAM controller. It times tREFI from the CSR-programmed timing fields and takes the SDRAM command bus away from the datapath. It then issues PRECHARGE ALL followed by AUTO REFRESH, honouring tRP and tRFC, and returns the bus to the datapath. It sits between the control interface (timing and bypass registers) and the datapath command mux.

Parameters:
- REF_CREDITS, 4: maximum postponed refreshes held in the credit counter. Used only with the optional feature.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  scheduler active; driven from (!bypass && !sdram_rst)
- tim_rp  in  3  wait cycles after PRECHARGE
- tim_rfc  in  4  wait cycles after AUTO REFRESH
- tim_refi  in  11  refresh interval in cycles
- dp_idle  in  1  datapath has no burst in flight
- dp_gnt  out  1  datapath may drive the command bus this cycle
- ref_busy  out  1  refresh sequence owns the bus
- ref_pending  out  1  at least one refresh owed
- cmd_cs_n  out  1  chip select, registered
- cmd_ras_n  out  1  RAS, registered
- cmd_cas_n  out  1  CAS, registered
- cmd_we_n  out  1  WE, registered
- cmd_adr  out  13  address; bit 10 = 1 during PRECHARGE ALL, otherwise 0
- cmd_ba  out  2  bank; always 0

Behaviour:
- Reset (async, sys_rst_n=0):
  - state IDLE; refi counter = 0; pending = 0.
  - dp_gnt=0, ref_busy=0, ref_pending=0.
  - cmd_cs_n/ras_n/cas_n/we_n = 1 (NOP/deselect); cmd_adr=0, cmd_ba=0.
- Interval counter (11-bit, down-counting):
  - While enable=0 it loads tim_refi every cycle.
  - While enable=1 it decrements. When it reads 0 it sets pending and reloads tim_refi on the same cycle.
  - Period is therefore tim_refi+1 cycles.
  - tim_refi=0 produces a request every cycle; this is legal, but the datapath starves.
- States:
  - IDLE: dp_gnt = enable && !pending. Go to DRAIN when enable && pending.
  - DRAIN: dp_gnt=0, ref_busy=1. Wait for dp_idle=1, then go to PRE.
  - PRE (1 cycle): drive PRECHARGE ALL (cs=0, ras=0, cas=1, we=0, adr[10]=1). Load the wait counter with tim_rp.
  - WAIT_RP: NOP; decrement wait counter; leave when it is 0. tim_rp=0 gives zero wait cycles.
  - REF (1 cycle): drive AUTO REFRESH (cs=0, ras=0, cas=0, we=1). Clear one pending. Load wait counter with tim_rfc.
  - WAIT_RFC: NOP; leave when the counter is 0. Return to IDLE, or to DRAIN if still pending. dp_gnt stays 0 when going straight to DRAIN.
- Command timing:
  - Commands are registered and appear on cmd_* the cycle after the state is entered.
  - The wait counter covers the full spacing: REF is driven exactly tim_rp+1 cycles after PRE on cmd_*.
- ref_busy is 1 in every state except IDLE. dp_gnt and ref_busy are never both 1.
- Simultaneous events:
  - Interval expiry in the same cycle as REF: the new request wins; pending stays 1.
  - Expiry during a sequence is remembered; pending is a single flag without the optional feature.
- enable falling mid-sequence: the sequence completes through WAIT_RFC, then stays in IDLE with dp_gnt=0. This avoids a tRP/tRFC violation.
- enable falling in DRAIN: return to IDLE; pending is cleared.
- Timing inputs are sampled only when a counter loads. Changes mid-wait take effect on the next load.

Optional Feature:
- Macro: HPDMC_REFRESH_POSTPONE_EN.
- Enabled:
  - pending becomes a credit counter of width clog2(REF_CREDITS+1). It increments on expiry and decrements on REF; expiry plus REF in the same cycle leaves it unchanged.
  - IDLE grants the datapath while 0 < credits < REF_CREDITS and dp_idle=0. Refresh starts when credits == REF_CREDITS, or when credits > 0 and dp_idle=1.
  - Back-to-back REFs skip PRE/WAIT_RP (WAIT_RFC goes to REF directly) while credits remain.
  - Saturates at REF_CREDITS.
- Disabled: single-flag behaviour as specified above.

Decomposition:
- Shared package hpdmc_pkg holds:
  - state encoding localparams;
  - command encodings CMD_NOP, CMD_PRECHARGE, CMD_REFRESH as {ras_n, cas_n, we_n};
  - timing field widths.
- One natural sub-module: hpdmc_refi_timer (interval down-counter plus pending/credit logic). The FSM stays in the top level.

Test Plan:
- Reset with sys_rst_n=0 asserted mid-WAIT_RFC -> cmd_* = NOP and dp_gnt=0 immediately (async); IDLE after release.
- enable=1, tim_refi=20, dp_idle=1 -> dp_gnt=1 for 20 cycles; then PRE, REF at the expected spacing, and a period of 21 cycles between PREs.
- tim_rp=2, tim_rfc=6 -> REF exactly 3 cycles after PRE on cmd_*; dp_gnt re-asserts 7 cycles after REF; adr[10]=1 only on PRE.
- Expiry while dp_idle=0 for 15 cycles -> stay in DRAIN with no command issued; PRE follows 1 cycle after dp_idle rises.
- enable dropped during WAIT_RP -> REF and WAIT_RFC still complete; then IDLE with dp_gnt=0 and the counter held at tim_refi.
- With HPDMC_REFRESH_POSTPONE_EN, REF_CREDITS=4, dp_idle=0 -> four expiries, then DRAIN, one PRE and four REFs spaced tim_rfc+1; credits back to 0.
